// File: rtl/mod_counter_bcd.sv
// Modulo-N time-field counter with tick carry, key editing and BCD display.
// One instance serves one field (seconds, minutes, hours, day, month).
module mod_counter_bcd #(
   parameter int WIDTH         = 6,
   parameter int MIN           = 0,
   parameter int MAX           = 23,
   parameter int RESET_VALUE   = 0,
   parameter int REPEAT_DELAY  = 25000000,
   parameter int REPEAT_PERIOD = 5000000
) (
   input  logic             clk_50,
   input  logic             rst,
   input  logic             mode,
   input  logic             select,
   input  logic             key1,
   input  logic             key2,
   input  logic             tick_in,
   input  logic             load_en,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] count,
   output logic [3:0]       tens,
   output logic [3:0]       ones,
   output logic             carry_out,
   output logic [6:0]       seg_tens,
   output logic [6:0]       seg_ones
);

   localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                         REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW   = $clog2(RMAX + 1);

   localparam logic [RW-1:0]    DLY_LAST = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0]    PER_LAST = RW'(REPEAT_PERIOD - 1);
   localparam logic [WIDTH-1:0] MIN_V    = WIDTH'(MIN);
   localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MAX);
   localparam logic [WIDTH-1:0] RST_V    = WIDTH'(RESET_VALUE);
   localparam logic [WIDTH-1:0] SPAN_V   = WIDTH'(MAX - MIN);

   typedef enum logic [1:0] {
      R_IDLE,
      R_DELAY,
      R_REPEAT
   } rep_e;

   logic [1:0]       s1_q, s1_d;
   logic [1:0]       s2_q, s2_d;
   logic [1:0]       p_q, p_d;
   logic [1:0]       arm_q, arm_d;
   logic [1:0]       warm_q, warm_d;
   rep_e             st_q [2];
   rep_e             st_d [2];
   logic [RW-1:0]    rc_q [2];
   logic [RW-1:0]    rc_d [2];
   logic             tick_d_q;
   logic [WIDTH-1:0] count_q, count_d;
   logic             carry_q, carry_d;

   logic [1:0]       step;
   logic             both;
   logic             active;
   logic             tick_edge;
   logic [WIDTH-1:0] load_off;
   logic [31:0]      c32;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'h40;
         4'd1:    seg7 = 7'h79;
         4'd2:    seg7 = 7'h24;
         4'd3:    seg7 = 7'h30;
         4'd4:    seg7 = 7'h19;
         4'd5:    seg7 = 7'h12;
         4'd6:    seg7 = 7'h02;
         4'd7:    seg7 = 7'h78;
         4'd8:    seg7 = 7'h00;
         4'd9:    seg7 = 7'h10;
         default: seg7 = 7'h7F;
      endcase
   endfunction

   // Key path: s1/s2 synchronise, p holds the previous level for edges.
   // arm blocks the first two post-reset cycles, whose s2/p are not real.
   always_comb begin
      s1_d      = {key2, key1};
      s2_d      = s1_q;
      p_d       = s2_q;
      warm_d    = {warm_q[0], 1'b1};
      arm_d     = arm_q | (s2_q & {2{warm_q[1]}});
      tick_edge = tick_in & ~tick_d_q;
      active    = mode & select;
      both      = ~s2_q[0] & ~s2_q[1];
      step      = 2'b00;
      for (int k = 0; k < 2; k++) begin
         st_d[k] = st_q[k];
         rc_d[k] = rc_q[k];
         if (load_en || !active || both) begin
            st_d[k] = R_IDLE;
            rc_d[k] = '0;
         end else if (st_q[k] == R_IDLE) begin
            rc_d[k] = '0;
            if (arm_q[k] && !s2_q[k] && p_q[k]) begin
               st_d[k] = R_DELAY;
               step[k] = 1'b1;
            end
         end else if (s2_q[k]) begin
            st_d[k] = R_IDLE;
            rc_d[k] = '0;
         end else if ((st_q[k] == R_DELAY && rc_q[k] == DLY_LAST) ||
                      (st_q[k] == R_REPEAT && rc_q[k] == PER_LAST)) begin
            st_d[k] = R_REPEAT;
            rc_d[k] = '0;
            step[k] = 1'b1;
         end else begin
            rc_d[k] = rc_q[k] + RW'(1);
         end
      end
   end

   // Out-of-range loads wrap below MIN in the subtraction, failing SPAN.
   always_comb begin
      count_d  = count_q;
      carry_d  = 1'b0;
      load_off = load_value - MIN_V;
      if (load_en) begin
         count_d = (load_off <= SPAN_V) ? load_value : MIN_V;
      end else if (!mode) begin
         if (tick_edge) begin
            if (count_q == MAX_V) begin
               count_d = MIN_V;
               carry_d = 1'b1;
            end else begin
               count_d = count_q + WIDTH'(1);
            end
         end
      end else if (select) begin
         if (step[0]) begin
            count_d = (count_q == MAX_V) ? MIN_V : count_q + WIDTH'(1);
         end else if (step[1]) begin
            count_d = (count_q == MIN_V) ? MAX_V : count_q - WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk_50) begin
      if (rst) begin
         s1_q     <= 2'b11;
         s2_q     <= 2'b11;
         p_q      <= 2'b11;
         arm_q    <= 2'b00;
         warm_q   <= 2'b00;
         st_q[0]  <= R_IDLE;
         st_q[1]  <= R_IDLE;
         rc_q[0]  <= '0;
         rc_q[1]  <= '0;
         tick_d_q <= 1'b0;
         count_q  <= RST_V;
         carry_q  <= 1'b0;
      end else begin
         s1_q     <= s1_d;
         s2_q     <= s2_d;
         p_q      <= p_d;
         arm_q    <= arm_d;
         warm_q   <= warm_d;
         st_q[0]  <= st_d[0];
         st_q[1]  <= st_d[1];
         rc_q[0]  <= rc_d[0];
         rc_q[1]  <= rc_d[1];
         tick_d_q <= tick_in;
         count_q  <= count_d;
         carry_q  <= carry_d;
      end
   end

   always_comb begin
      c32      = 32'(count_q);
      tens     = 4'(c32 / 32'd10);
      ones     = 4'(c32 % 32'd10);
      seg_tens = seg7(tens);
      seg_ones = seg7(ones);
   end

   assign count     = count_q;
   assign carry_out = carry_q;

endmodule
